graphics_score_display: RTL and testbench
=========================================

// Module: graphics_score_display
// PURPOSE
//  Parametrised score readout for the VGA pixel pipeline. Samples a binary score once per frame, converts it
//  to BCD with a sequential shift-add-3 engine, holds the result tear-free for the frame, and renders
//  NUM_DIGITS 8x8 glyphs with integer pixel scaling and optional leading-zero blanking.
//  Sits beside the other graphics_* layers; its colour output is merged by the top-level priority mux.
// PARAMETERS
//  SCORE_W     18     width of binary score input
//  NUM_DIGITS  7      digit slots drawn, including any trailing fixed zero
//  TRAIL_ZERO  1      1: rightmost slot always shows '0' (score counts tens); 0: none
//  X_OFF       8      left edge of readout, pixels
//  Y_OFF       8      top edge of readout, pixels
//  SCALE_LOG2  0      glyph magnification = 2**SCALE_LOG2 (pixel replication)
//  FG          8'hFF  lit glyph pixel colour;  BG  8'h00  all other pixels
// PORTS
//  clk          in   1        pixel clock
//  rst_n        in   1        asynchronous active-low reset
//  xpos         in   9        current pixel x
//  ypos         in   9        current pixel y
//  score        in   SCORE_W  binary score (tens when TRAIL_ZERO=1)
//  frame_start  in   1        one-cycle pulse at start of vertical blank; requests a sample
//  blank_lz     in   1        1: suppress leading zeros; 0: show all slots
//  color        out  8        registered pixel colour
//  busy         out  1        conversion in progress
// BEHAVIOUR
//  Reset (async assert, sync release): FSM=IDLE, busy=0, disp_bcd=0, color=BG; in-flight conversion discarded.
//  Derived: CONV_D = NUM_DIGITS-TRAIL_ZERO; ACC_D = (SCORE_W+2)/3 BCD digits in the accumulator.
//  FSM IDLE -> CONV -> DONE -> IDLE.
//   IDLE: frame_start=1 -> load shift reg with score, clear acc, cnt=0, go CONV. Otherwise hold.
//   CONV: each cycle, every acc digit >=5 gets +3, then {acc,shift} shifts left 1. After SCORE_W CONV
//     cycles -> DONE.
//   DONE: one cycle; disp_bcd <= low CONV_D acc digits, or all 9s if any acc digit >= CONV_D is nonzero
//     (saturation); -> IDLE.
//  busy=1 in CONV and DONE; disp_bcd changes on the (SCORE_W+1)th edge after the edge sampling frame_start.
//  frame_start while busy is ignored (no queueing). Changes on score after sampling have no effect.
//  Pixel path, latency 1: color at edge N reflects xpos/ypos present before edge N.
//   Window: X_OFF <= x < X_OFF + 8*NUM_DIGITS<<SCALE_LOG2, Y_OFF <= y < Y_OFF + 8<<SCALE_LOG2; outside -> BG.
//   dx=(x-X_OFF)>>SCALE_LOG2, dy=(y-Y_OFF)>>SCALE_LOG2; slot=dx>>3 (0 = leftmost), col=dx[2:0], row=dy[2:0].
//   Slot value: slot NUM_DIGITS-1 is '0' when TRAIL_ZERO=1, else disp_bcd digit by position (MSD left).
//   Glyph bit index 63-(row*8+col) of the 64-bit font word (bit 63 = top-left pixel); lit -> FG.
//   blank_lz=1: converted slots left of the most significant nonzero digit draw BG; the least significant
//     converted digit and the trailing zero are never blanked (score 0 shows "00").
//  All address arithmetic is 10 bits wide so no wrap occurs for x,y <= 511.
// STRUCTURE
//  graphics_pkg: DIGIT_FONT[0:9] (64-bit 8x8 glyphs), colour constants, score_fsm_t enum {IDLE,CONV,DONE}.
//  Sub-module bin2bcd_seq (W, DIGITS; start, busy, done pulse, bcd out) holds the FSM and shift-add-3
//  datapath; the top holds disp_bcd, saturation, blanking and the registered pixel mux.
// TESTING
//  1 Reset low mid-CONV (score=12345) -> busy=0, color=BG immediately; disp_bcd=0; after release with
//    blank_lz=1 the readout shows "00".
//  2 score=12345, frame_start pulse -> busy high 19 cycles; disp_bcd=123450 as drawn; pixel (8,8) lag 1 = BG
//    (blanked slot), first lit pixels start in slot 1.
//  3 score=262143, NUM_DIGITS=6, TRAIL_ZERO=1 (CONV_D=5) -> saturates, draws "999990".
//  4 Sample score=7, then score=8 while busy with a second frame_start -> pulse ignored, display stays
//    "70" until the next frame_start.
//  5 SCALE_LOG2=1, score=1 -> glyph '1' occupies 16x16 pixel blocks; x=X_OFF+16*7*2 = outside window -> BG.
//  6 blank_lz=0, score=5 -> all 7 slots drawn "0000050"; sweep row 0..7 and compare against DIGIT_FONT.

Source files
------------

// File: rtl/graphics_score_display_pkg.sv
// Shared types and constants for the score readout layer: FSM states, default colours and the 8x8 digit font.
// Font rows run top to bottom in bytes 7..0; bit 63 is the top-left pixel.
package graphics_score_display_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } score_fsm_t;

  localparam logic [7:0] COLOR_FG = 8'hFF;
  localparam logic [7:0] COLOR_BG = 8'h00;

  localparam logic [63:0] DIGIT_FONT [0:9] = '{
    64'h3C666E7666663C00,  // 0
    64'h1838181818187E00,  // 1
    64'h3C66060C30607E00,  // 2
    64'h3C66061C06663C00,  // 3
    64'h0C1C3C6C7E0C0C00,  // 4
    64'h7E607C0606663C00,  // 5
    64'h3C66607C66663C00,  // 6
    64'h7E060C1818181800,  // 7
    64'h3C66663C66663C00,  // 8
    64'h3C66663E06663C00   // 9
  };

  // Non-decimal codes never reach the renderer, but they draw nothing rather than indexing past the font.
  function automatic logic glyph_pixel(input logic [3:0] digit, input logic [2:0] row, input logic [2:0] col);
    logic [63:0] word;
    word = (digit <= 4'd9) ? DIGIT_FONT[digit] : 64'd0;
    return word[6'd63 - {row, col}];
  endfunction

endpackage

// File: rtl/graphics_score_display_if.sv
// Pixel-pipeline and score-sampling signals of the score readout, with driver (master) and readout (slave) views.
interface graphics_score_display_if #(
  parameter int SCORE_W = 18
);
  logic [8:0]         xpos;
  logic [8:0]         ypos;
  logic [SCORE_W-1:0] score;
  logic               frame_start;
  logic               blank_lz;
  logic [7:0]         color;
  logic               busy;

  modport master (output xpos, ypos, score, frame_start, blank_lz, input color, busy);
  modport slave  (input xpos, ypos, score, frame_start, blank_lz, output color, busy);
endinterface

// File: rtl/graphics_score_display_bin2bcd.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per cycle; done pulses for the single cycle
// in which bcd holds the finished result.
module bin2bcd_seq
  import graphics_score_display_pkg::*;
#(
  parameter int W      = 18,
  parameter int DIGITS = (W + 2) / 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [W-1:0]          bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int              CNT_W    = (W > 1) ? $clog2(W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  score_fsm_t          state, state_next;
  logic [W-1:0]        shift_q;
  logic [4*DIGITS-1:0] acc_q;
  logic [4*DIGITS-1:0] acc_adj;
  logic [CNT_W-1:0]    cnt_q;
  logic                load;
  logic                step;

  // NOTE: flops use non-blocking (<=) so every register samples pre-edge values regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every output of a combinational block is defaulted first, so no path can leave it unassigned (no latch).
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    load       = 1'b0;
    step       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = CONV;
        end
      end
      CONV: begin
        busy = 1'b1;
        step = 1'b1;
        if (cnt_q == CNT_LAST) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    acc_adj = acc_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (acc_q[4*d +: 4] >= 4'd5) acc_adj[4*d +: 4] = acc_q[4*d +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else if (load) begin
      shift_q <= bin;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else if (step) begin
      {acc_q, shift_q} <= {acc_adj, shift_q} << 1;
      cnt_q            <= cnt_q + 1'b1;
    end
  end

  assign bcd = acc_q;

endmodule

// File: rtl/graphics_score_display.sv
// Score readout layer: samples the score each frame, holds the converted BCD tear-free, and draws scaled
// 8x8 glyphs with optional leading-zero blanking through a one-cycle registered pixel path.
module graphics_score_display
  import graphics_score_display_pkg::*;
#(
  parameter int         SCORE_W    = 18,
  parameter int         NUM_DIGITS = 7,
  parameter int         TRAIL_ZERO = 1,
  parameter int         X_OFF      = 8,
  parameter int         Y_OFF      = 8,
  parameter int         SCALE_LOG2 = 0,
  parameter logic [7:0] FG         = COLOR_FG,
  parameter logic [7:0] BG         = COLOR_BG
) (
  input logic                      clk,
  input logic                      rst_n,
  graphics_score_display_if.slave  bus
);

  localparam int CONV_D = NUM_DIGITS - TRAIL_ZERO;
  localparam int ACC_D  = (SCORE_W + 2) / 3;
  localparam int PAD_D  = (CONV_D > ACC_D) ? CONV_D : ACC_D;
  localparam int PAD_W  = 4 * PAD_D;
  localparam int WIN_W  = (8 * NUM_DIGITS) << SCALE_LOG2;
  localparam int WIN_H  = 8 << SCALE_LOG2;

  localparam logic [9:0] X_LO = 10'(X_OFF);
  localparam logic [9:0] X_HI = 10'(X_OFF + WIN_W);
  localparam logic [9:0] Y_LO = 10'(Y_OFF);
  localparam logic [9:0] Y_HI = 10'(Y_OFF + WIN_H);

  logic                conv_done;
  logic [4*ACC_D-1:0]  acc_bcd;
  logic [PAD_W-1:0]    acc_pad;
  logic                saturated;
  logic [4*CONV_D-1:0] disp_bcd;

  bin2bcd_seq #(
    .W      (SCORE_W),
    .DIGITS (ACC_D)
  ) u_bin2bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (bus.frame_start),
    .bin   (bus.score),
    .busy  (bus.busy),
    .done  (conv_done),
    .bcd   (acc_bcd)
  );

  // The accumulator may be narrower or wider than the drawn field; padding lets both cases share one path.
  assign acc_pad   = PAD_W'(acc_bcd);
  assign saturated = |(acc_pad >> (4 * CONV_D));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         disp_bcd <= '0;
    else if (conv_done) disp_bcd <= saturated ? {CONV_D{4'h9}} : acc_pad[4*CONV_D-1:0];
  end

  logic [9:0] x10, y10, dx;
  logic       in_win;
  logic [6:0] slot;
  logic [2:0] col, row;
  logic [3:0] glyph_digit;
  logic       blank_slot;
  logic       zeros_left;
  logic       lit;

  assign x10    = {1'b0, bus.xpos};
  assign y10    = {1'b0, bus.ypos};
  assign in_win = (x10 >= X_LO) && (x10 < X_HI) && (y10 >= Y_LO) && (y10 < Y_HI);
  assign dx     = (x10 - X_LO) >> SCALE_LOG2;
  assign slot   = 7'(dx >> 3);
  assign col    = dx[2:0];
  assign row    = 3'((y10 - Y_LO) >> SCALE_LOG2);

  // Slots are scanned MSD first; zeros_left stays set while every digit up to the current slot is zero.
  // Slots past the converted field fall through to the default digit 0 (the fixed trailing zero).
  always_comb begin
    glyph_digit = 4'd0;
    blank_slot  = 1'b0;
    zeros_left  = 1'b1;
    for (int s = 0; s < CONV_D; s++) begin
      zeros_left = zeros_left && (disp_bcd[4*(CONV_D-1-s) +: 4] == 4'd0);
      if (slot == 7'(s)) begin
        glyph_digit = disp_bcd[4*(CONV_D-1-s) +: 4];
        blank_slot  = bus.blank_lz && zeros_left && (s != CONV_D - 1);
      end
    end
  end

  assign lit = glyph_pixel(glyph_digit, row, col);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.color <= BG;
    else        bus.color <= (in_win && !blank_slot && lit) ? FG : BG;
  end

endmodule

// File: tb/tb_graphics_score_display.sv
// Directed bench for graphics_score_display: stimulus pushes expectations tagged with the cycle they become
// observable; a negedge monitor pops and compares them. Three instances cover default, 6-digit and 2x scale.
module tb_graphics_score_display;
  import graphics_score_display_pkg::*;

  localparam logic [7:0] FG = 8'hFF;
  localparam logic [7:0] BG = 8'h00;
  localparam int K_COLOR = 0;
  localparam int K_BUSY  = 1;
  localparam int K_DISP  = 2;

  localparam logic [63:0] REF_FONT [0:9] = '{
    64'h3C666E7666663C00, 64'h1838181818187E00, 64'h3C66060C30607E00, 64'h3C66061C06663C00,
    64'h0C1C3C6C7E0C0C00, 64'h7E607C0606663C00, 64'h3C66607C66663C00, 64'h7E060C1818181800,
    64'h3C66663C66663C00, 64'h3C66663E06663C00
  };

  typedef struct {
    int          due;
    int          kind;
    int          dut;
    logic [31:0] exp;
    string       name;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb[$];

  graphics_score_display_if #(.SCORE_W(18)) bus0 ();
  graphics_score_display_if #(.SCORE_W(18)) bus1 ();
  graphics_score_display_if #(.SCORE_W(18)) bus2 ();

  graphics_score_display u0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  graphics_score_display #(.NUM_DIGITS(6)) u1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  graphics_score_display #(.SCALE_LOG2(1)) u2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [31:0] actual(input int kind, input int d);
    logic [31:0] v;
    v = '0;
    case (kind)
      K_COLOR: v = (d == 0) ? 32'(bus0.color) : (d == 1) ? 32'(bus1.color) : 32'(bus2.color);
      K_BUSY:  v = (d == 0) ? 32'(bus0.busy)  : (d == 1) ? 32'(bus1.busy)  : 32'(bus2.busy);
      default: v = (d == 0) ? 32'(u0.disp_bcd) : (d == 1) ? 32'(u1.disp_bcd) : 32'(u2.disp_bcd);
    endcase
    return v;
  endfunction

  // Monitor: every expectation is compared at the negedge of the cycle it was tagged for.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due < cyc) begin
        n_checks++;
        $display("FAIL %s: got no sample expected %0h", sb[i].name, sb[i].exp);
        sb.delete(i);
      end else if (sb[i].due == cyc) begin
        check(sb[i].name, actual(sb[i].kind, sb[i].dut), sb[i].exp);
        sb.delete(i);
      end
    end
  end

  task automatic expect_at(input int due, input int kind, input int d, input logic [31:0] exp, input string name);
    exp_t e;
    e.due = due; e.kind = kind; e.dut = d; e.exp = exp; e.name = name;
    sb.push_back(e);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_pix(input int d, input int x, input int y);
    case (d)
      0:       begin bus0.xpos = 9'(x); bus0.ypos = 9'(y); end
      1:       begin bus1.xpos = 9'(x); bus1.ypos = 9'(y); end
      default: begin bus2.xpos = 9'(x); bus2.ypos = 9'(y); end
    endcase
  endtask

  task automatic set_score(input int d, input int s);
    case (d)
      0:       bus0.score = 18'(s);
      1:       bus1.score = 18'(s);
      default: bus2.score = 18'(s);
    endcase
  endtask

  task automatic set_fs(input int d, input logic v);
    case (d)
      0:       bus0.frame_start = v;
      1:       bus1.frame_start = v;
      default: bus2.frame_start = v;
    endcase
  endtask

  task automatic set_blank(input int d, input logic v);
    case (d)
      0:       bus0.blank_lz = v;
      1:       bus1.blank_lz = v;
      default: bus2.blank_lz = v;
    endcase
  endtask

  // Pixel presented now must appear on color after the next active edge.
  task automatic probe(input int d, input int x, input int y, input logic [7:0] exp, input string name);
    set_pix(d, x, y);
    expect_at(cyc + 1, K_COLOR, d, 32'(exp), name);
    step();
  endtask

  // Busy is high for 19 cycles after the sampling edge; disp_bcd changes on the 19th edge after it.
  task automatic convert(input int d, input int score, input logic [31:0] old_disp, input logic [31:0] new_disp,
                         input string name);
    int t0;
    t0 = cyc;
    set_score(d, score);
    set_fs(d, 1'b1);
    for (int i = 1; i <= 20; i++) expect_at(t0 + i, K_BUSY, d, 32'(i <= 19), {name, " busy"});
    expect_at(t0 + 19, K_DISP, d, old_disp, {name, " disp before"});
    expect_at(t0 + 20, K_DISP, d, new_disp, {name, " disp after"});
    step();
    set_fs(d, 1'b0);
    repeat (19) step();
  endtask

  initial begin
    int t0;
    logic [63:0] g;
    for (int d = 0; d < 3; d++) begin
      set_pix(d, 0, 0);
      set_score(d, 0);
      set_fs(d, 1'b0);
      set_blank(d, 1'b1);
    end
    rst_n = 1'b0;
    repeat (3) step();
    check("reset busy", 32'(bus0.busy), 32'd0);
    check("reset color", 32'(bus0.color), 32'(BG));
    check("reset disp", 32'(u0.disp_bcd), 32'd0);
    rst_n = 1'b1;
    step();

    // Reset asserted mid-conversion clears busy and color at once and discards the result.
    set_blank(0, 1'b0);
    probe(0, 10, 8, FG, "t1 unblanked zero");
    set_score(0, 12345);
    set_fs(0, 1'b1);
    step();
    set_fs(0, 1'b0);
    repeat (5) step();
    check("t1 busy mid-conv", 32'(bus0.busy), 32'd1);
    check("t1 color before reset", 32'(bus0.color), 32'(FG));
    #2;
    rst_n = 1'b0;
    #1;
    check("t1 async busy", 32'(bus0.busy), 32'd0);
    check("t1 async color", 32'(bus0.color), 32'(BG));
    check("t1 async disp", 32'(u0.disp_bcd), 32'd0);
    step();
    rst_n = 1'b1;
    set_blank(0, 1'b1);
    probe(0, 10, 8, BG, "t1 slot0 blanked");
    probe(0, 42, 8, BG, "t1 slot4 blanked");
    probe(0, 50, 8, FG, "t1 slot5 zero kept");
    probe(0, 58, 8, FG, "t1 trailing zero");
    repeat (20) step();
    expect_at(cyc + 1, K_BUSY, 0, 32'd0, "t1 no restart busy");
    expect_at(cyc + 1, K_DISP, 0, 32'd0, "t1 disp discarded");
    step();

    // 12345 -> "123450" with slot 0 blanked.
    convert(0, 12345, 32'd0, 32'h012345, "t2");
    probe(0, 8, 8, BG, "t2 origin blank");
    probe(0, 10, 8, BG, "t2 slot0 blanked");
    probe(0, 19, 8, FG, "t2 one r0c3");
    probe(0, 18, 8, BG, "t2 one r0c2");
    probe(0, 17, 14, FG, "t2 one r6c1");
    probe(0, 17, 16, BG, "t2 below window");
    probe(0, 25, 9, FG, "t2 two r1c1");
    probe(0, 35, 11, FG, "t2 three r3c3");
    probe(0, 49, 10, FG, "t2 five r2c1");
    probe(0, 54, 10, BG, "t2 five r2c6");
    probe(0, 57, 9, FG, "t2 trail r1c1");
    probe(0, 57, 15, BG, "t2 trail r7");
    probe(0, 64, 9, BG, "t2 right of window");

    // A second frame_start while busy is dropped, and score changes after sampling are ignored.
    t0 = cyc;
    set_score(0, 7);
    set_fs(0, 1'b1);
    expect_at(t0 + 1, K_BUSY, 0, 32'd1, "t4 busy start");
    step();
    set_fs(0, 1'b0);
    set_score(0, 8);
    repeat (4) step();
    set_fs(0, 1'b1);
    step();
    set_fs(0, 1'b0);
    expect_at(t0 + 19, K_BUSY, 0, 32'd1, "t4 busy last");
    expect_at(t0 + 19, K_DISP, 0, 32'h012345, "t4 disp held");
    expect_at(t0 + 20, K_BUSY, 0, 32'd0, "t4 busy not extended");
    expect_at(t0 + 20, K_DISP, 0, 32'h000007, "t4 disp seven");
    while (cyc < t0 + 22) step();
    expect_at(cyc + 1, K_DISP, 0, 32'h000007, "t4 disp stays");
    probe(0, 49, 8, FG, "t4 seven r0c1");
    probe(0, 42, 8, BG, "t4 slot4 blanked");
    convert(0, 8, 32'h000007, 32'h000008, "t4 next frame");

    // Unblanked readout of 5: "0000050"; full glyph sweep of slot 5.
    set_blank(0, 1'b0);
    convert(0, 5, 32'h000008, 32'h000005, "t6");
    probe(0, 10, 8, FG, "t6 leading zero drawn");
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        g = REF_FONT[5];
        probe(0, 48 + c, 8 + r, g[63 - (r * 8 + c)] ? FG : BG, $sformatf("t6 five r%0dc%0d", r, c));
      end
    end

    // Six slots, five converted: 262143 saturates to "999990".
    convert(1, 262143, 32'd0, 32'h99999, "t3");
    probe(1, 10, 11, FG, "t3 nine r3c2");
    probe(1, 9, 11, BG, "t3 nine r3c1");
    probe(1, 42, 11, FG, "t3 slot4 nine");
    probe(1, 50, 8, FG, "t3 trailing zero");
    probe(1, 57, 9, BG, "t3 right of window");

    // 2x scale, score 1: "10" in 16x16 glyphs.
    convert(2, 1, 32'd0, 32'h000001, "t5");
    probe(2, 94, 8, FG, "t5 one r0c3");
    probe(2, 97, 9, FG, "t5 one r0c4");
    probe(2, 93, 8, BG, "t5 one r0c2");
    probe(2, 98, 8, BG, "t5 one r0c5");
    probe(2, 92, 10, FG, "t5 one r1c2");
    probe(2, 92, 8, BG, "t5 one r0c2 low");
    probe(2, 76, 8, BG, "t5 slot4 blanked");
    probe(2, 108, 20, FG, "t5 trail r6c2");
    probe(2, 108, 24, BG, "t5 below window");
    probe(2, 120, 20, BG, "t5 right edge");
    probe(2, 232, 8, BG, "t5 far right");

    repeat (3) step();
    while (sb.size() != 0) begin
      n_checks++;
      $display("FAIL %s: got no sample expected %0h", sb[0].name, sb[0].exp);
      void'(sb.pop_front());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
